// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and rotating-priority helper for the FIFO write arbiter
// and any matching read-side scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_DW         = 8;
    localparam int DEF_FIFO_DEPTH = 8;

    // Index that follows idx in a ring of n requesters.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last' in ring order.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    int unsigned      idx;
    logic [IDX_W-1:0] pos;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 32'(last);
        pos    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = next_idx(idx, N_REQ);
            pos = IDX_W'(idx);
            if (!valid && req[pos]) begin
                winner[pos] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write port of a synchronous FIFO.
// Optional stall statistics counter enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data_in,
    input  logic                fifo_full,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    grant,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_data,
    output logic                busy,
    output logic [15:0]         stall_cnt
);

    localparam int               IDX_W      = $clog2(N_REQ);
    localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_REQ - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] gidx;
    logic [3:0]       beat_cnt;
    logic [N_REQ-1:0] pick;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             g_req;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    assign g_req   = req[gidx];
    assign ack     = grant & req & {N_REQ{~fifo_full}};
    // A reset cycle must never reach the FIFO, even with a live grant.
    assign fifo_wr = (|ack) & ~rst;

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) fifo_data = fifo_data | data_in[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            last     <= LAST_RST;
            gidx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        grant    <= pick;
                        gidx     <= pick_idx;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    // Full only freezes the burst; only a drop or the last beat ends it.
                    if (!g_req || (fifo_wr && beat_cnt == BURST_LAST)) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        last     <= gidx;
                    end else if (fifo_wr) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == GRANT && g_req && fifo_full && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a behavioural ring-arbiter model; honours FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic            fifo_full;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_data;
    logic            busy;
    logic [15:0]     stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic         busy;
        logic         wr;
        logic [15:0]  stall;
    } exp_t;

    exp_t          cq[$];
    logic [DW-1:0] wq[$];

    // Model state: owner = granted requester or -1 when idle.
    int m_owner, m_beats, m_last, m_stall;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .ack       (ack),
        .grant     (grant),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        m_stall = 0;
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                        input logic f, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r; data_in = d; fifo_full = f; rst = rs;

        e.grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
        e.busy  = (m_owner >= 0);
        e.ack   = (m_owner >= 0 && r[m_owner] && !f) ? N'(1 << m_owner) : '0;
        e.wr    = (e.ack != 0) && !rs;
        e.stall = 16'(m_stall);
        cq.push_back(e);
        if (e.wr) wq.push_back(d[m_owner*DW +: DW]);

        if (rs) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (f) begin
`ifdef FIFO_ARB_STATS_EN
            if (m_stall < 65535) m_stall++;
`endif
        end else begin
            m_beats++;
            if (m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        return {$urandom};
    endfunction

    // Monitor: checks every presented cycle and every FIFO write independently.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                cmp("grant", 32'(grant), 32'(e.grant));
                cmp("ack", 32'(ack), 32'(e.ack));
                cmp("busy", 32'(busy), 32'(e.busy));
                cmp("fifo_wr", 32'(fifo_wr), 32'(e.wr));
                cmp("stall_cnt", 32'(stall_cnt), 32'(e.stall));
            end
            if (fifo_wr === 1'b1) begin
                if (wq.size() == 0) begin
                    cmp("unexpected_write", 32'(fifo_wr), 32'd0);
                end else begin
                    cmp("fifo_data", 32'(fifo_data), 32'(wq.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rr;
        rst = 1'b1; req = '0; data_in = '0; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        model_reset();

        // Single requester with A5 data: bursts of MB separated by one idle cycle.
        repeat (12) step(4'b0001, {24'h0, 8'hA5}, 1'b0, 1'b0);
        repeat (2) step(4'b0000, '0, 1'b0, 1'b0);

        // All requesting: rotation 1,2,3,0,... after last=0.
        repeat (24) step(4'b1111, rnd_data(), 1'b0, 1'b0);
        repeat (2) step(4'b0000, '0, 1'b0, 1'b0);

        // Requester 2 alone: full after two beats for five cycles.
        repeat (3) step(4'b0100, rnd_data(), 1'b0, 1'b0);
        repeat (5) step(4'b0100, rnd_data(), 1'b1, 1'b0);
        repeat (3) step(4'b0100, rnd_data(), 1'b0, 1'b0);
        repeat (3) step(4'b0000, '0, 1'b0, 1'b0);

        // Requester 1 drops after one beat; pending 3 beats pending 0.
        step(4'b0010, rnd_data(), 1'b0, 1'b0);
        step(4'b1010, rnd_data(), 1'b0, 1'b0);
        step(4'b1001, rnd_data(), 1'b0, 1'b0);
        repeat (7) step(4'b1001, rnd_data(), 1'b0, 1'b0);
        repeat (2) step(4'b0000, '0, 1'b0, 1'b0);

        // Reset during beat 2, then requester 0 must win over 2.
        step(4'b0001, rnd_data(), 1'b0, 1'b0);
        step(4'b0001, rnd_data(), 1'b0, 1'b0);
        step(4'b0001, rnd_data(), 1'b0, 1'b1);
        repeat (6) step(4'b0101, rnd_data(), 1'b0, 1'b0);

        // Random traffic with sticky requests, full and rare resets.
        rr = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(5) == 0) rr[b] = ~rr[b];
            step(rr, rnd_data(), ($urandom_range(3) == 0), ($urandom_range(299) == 0));
        end
        step(4'b0000, '0, 1'b0, 1'b1);

`ifdef FIFO_ARB_STATS_EN
        // Long full stall drives the counter into saturation.
        repeat (65545) step(4'b0001, rnd_data(), 1'b1, 1'b0);
        repeat (3) step(4'b0001, rnd_data(), 1'b0, 1'b0);
`endif

        repeat (3) step(4'b0000, '0, 1'b0, 1'b0);
        @(negedge clk);
        #5;
        cmp("queue_drained", 32'(cq.size() + wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
